// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for a multi-cycle MIPS datapath: fetch/decode/execute/memory/write-back sequencing.
// Latency: lw 5, sw/R-type/imm/jr 4, beq/j 3, bad opcode 2 cycles; +1 per mem_ready=0 cycle in S0/S3/S5.
// Backpressure: stalls in FETCH, MEMRD and MEMWR until mem_ready; all outputs forced low while rst_n is low.
//
// Ports: clk/rst_n (async active-low), opcode (IR[31:26]), JumpReg (from ALU control),
//        mem_ready (memory handshake); outputs are datapath strobes, mux selects, ALUOp,
//        illegal_op pulse and the current state for debug.
module mips_multicycle_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       JumpReg,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       ALUSrcA,
   output logic       ZeroExt,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSource,
   output logic [2:0] ALUOp,
   output logic       illegal_op,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RWB    = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_IEXEC  = 4'd10,
      S_JR     = 4'd11,
      S_IWB    = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   state_t cur;
   state_t nxt;

   // Next-state decode. Encodings 13-15 fall into the default and return to FETCH.
   always_comb begin
      nxt = S_FETCH;
      case (cur)
         S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:                   nxt = S_EXEC;
               OP_LW, OP_SW:               nxt = S_MEMADR;
               OP_BEQ:                     nxt = S_BRANCH;
               OP_J:                       nxt = S_JUMP;
               OP_ADDI, OP_ANDI, OP_ORI:   nxt = S_IEXEC;
               default:                    nxt = S_FETCH;
            endcase
         end
         // Only lw and sw reach MEMADR, so anything other than sw is a load.
         S_MEMADR: nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  nxt = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:  nxt = S_FETCH;
         S_MEMWR:  nxt = mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC:   nxt = JumpReg ? S_JR : S_RWB;
         S_RWB:    nxt = S_FETCH;
         S_BRANCH: nxt = S_FETCH;
         S_JUMP:   nxt = S_FETCH;
         S_IEXEC:  nxt = S_IWB;
         S_JR:     nxt = S_FETCH;
         S_IWB:    nxt = S_FETCH;
         default:  nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cur <= S_FETCH;
      else        cur <= nxt;
   end

   // Controls are decoded combinationally from the state because FETCH/MEMWR strobes
   // must follow mem_ready in the same cycle and reset must kill them without a clock.
   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      ALUSrcA     = 1'b0;
      ZeroExt     = 1'b0;
      ALUSrcB     = 2'b00;
      PCSource    = 2'b00;
      ALUOp       = 3'b000;
      illegal_op  = 1'b0;
      case (cur)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            // PC and IR load only on the completing fetch cycle, so a stall never double-updates.
            IRWrite = mem_ready;
            PCWrite = mem_ready;
         end
         S_DECODE: begin
            ALUSrcB = 2'b11;
            case (opcode)
               OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J,
               OP_ADDI, OP_ANDI, OP_ORI: illegal_op = 1'b0;
               default:                  illegal_op = 1'b1;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_MEMWB: begin
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
         end
         S_MEMWR: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
         end
         S_EXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = 3'b010;
         end
         S_RWB: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = 3'b001;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
         end
         S_JUMP: begin
            PCWrite  = 1'b1;
            PCSource = 2'b10;
         end
         S_IEXEC: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            case (opcode)
               OP_ANDI: begin ALUOp = 3'b011; ZeroExt = 1'b1; end
               OP_ORI:  begin ALUOp = 3'b100; ZeroExt = 1'b1; end
               default: ALUOp = 3'b000;
            endcase
         end
         S_JR: begin
            PCWrite  = 1'b1;
            PCSource = 2'b11;
            ALUOp    = 3'b010;
         end
         S_IWB: begin
            RegWrite = 1'b1;
         end
         default: ;
      endcase

      // Reset gating is combinational so an in-flight write is abandoned the instant rst_n falls.
      if (!rst_n) begin
         PCWrite     = 1'b0;
         PCWriteCond = 1'b0;
         IorD        = 1'b0;
         MemRead     = 1'b0;
         MemWrite    = 1'b0;
         IRWrite     = 1'b0;
         MemtoReg    = 1'b0;
         RegWrite    = 1'b0;
         RegDst      = 1'b0;
         ALUSrcA     = 1'b0;
         ZeroExt     = 1'b0;
         ALUSrcB     = 2'b00;
         PCSource    = 2'b00;
         ALUOp       = 3'b000;
         illegal_op  = 1'b0;
      end
   end

   assign state = cur;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: per-cycle vector table plus hand-written stall/reset sequences.
// Expected values are queued when inputs are driven and compared at the following falling edge.
// Prints one summary line and finishes; a watchdog bounds the run.
module tb_mips_multicycle_ctrl;

   logic       clk;
   logic       rst_n;
   logic [5:0] opcode;
   logic       JumpReg;
   logic       mem_ready;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, RegWrite, RegDst, ALUSrcA, ZeroExt;
   logic [1:0] ALUSrcB, PCSource;
   logic [2:0] ALUOp;
   logic       illegal_op;
   logic [3:0] state;

   mips_multicycle_ctrl dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .JumpReg(JumpReg), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
      .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ZeroExt(ZeroExt), .ALUSrcB(ALUSrcB),
      .PCSource(PCSource), .ALUOp(ALUOp), .illegal_op(illegal_op), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observed word: state, 11 strobes, ALUSrcB, PCSource, ALUOp, illegal_op.
   logic [22:0] obs_now;
   assign obs_now = {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                     MemtoReg, RegWrite, RegDst, ALUSrcA, ZeroExt,
                     ALUSrcB, PCSource, ALUOp, illegal_op};

   // Control bit order: pcw pcwc iord mrd mwr irw m2r rw rdst srca zext | srcb | pcsrc | aluop | ill
   localparam logic [18:0] C_ZERO       = 19'b0;
   localparam logic [18:0] C_FETCH_RDY  = 19'b1_0_0_1_0_1_0_0_0_0_0_01_00_000_0;
   localparam logic [18:0] C_FETCH_WAIT = 19'b0_0_0_1_0_0_0_0_0_0_0_01_00_000_0;
   localparam logic [18:0] C_DECODE     = 19'b0_0_0_0_0_0_0_0_0_0_0_11_00_000_0;
   localparam logic [18:0] C_DECODE_ILL = 19'b0_0_0_0_0_0_0_0_0_0_0_11_00_000_1;
   localparam logic [18:0] C_MEMADR     = 19'b0_0_0_0_0_0_0_0_0_1_0_10_00_000_0;
   localparam logic [18:0] C_MEMRD      = 19'b0_0_1_1_0_0_0_0_0_0_0_00_00_000_0;
   localparam logic [18:0] C_MEMWB      = 19'b0_0_0_0_0_0_1_1_0_0_0_00_00_000_0;
   localparam logic [18:0] C_MEMWR      = 19'b0_0_1_0_1_0_0_0_0_0_0_00_00_000_0;
   localparam logic [18:0] C_EXEC       = 19'b0_0_0_0_0_0_0_0_0_1_0_00_00_010_0;
   localparam logic [18:0] C_RWB        = 19'b0_0_0_0_0_0_0_1_1_0_0_00_00_000_0;
   localparam logic [18:0] C_BRANCH     = 19'b0_1_0_0_0_0_0_0_0_1_0_00_01_001_0;
   localparam logic [18:0] C_JUMP       = 19'b1_0_0_0_0_0_0_0_0_0_0_00_10_000_0;
   localparam logic [18:0] C_ADDI       = 19'b0_0_0_0_0_0_0_0_0_1_0_10_00_000_0;
   localparam logic [18:0] C_ANDI       = 19'b0_0_0_0_0_0_0_0_0_1_1_10_00_011_0;
   localparam logic [18:0] C_ORI        = 19'b0_0_0_0_0_0_0_0_0_1_1_10_00_100_0;
   localparam logic [18:0] C_JR         = 19'b1_0_0_0_0_0_0_0_0_0_0_00_11_010_0;
   localparam logic [18:0] C_IWB        = 19'b0_0_0_0_0_0_0_1_0_0_0_00_00_000_0;

   typedef struct {
      logic        rst;
      logic [5:0]  op;
      logic        jr;
      logic        rdy;
      logic [3:0]  st;
      logic [18:0] ctl;
   } vec_t;

   vec_t        tbl[$];
   logic [22:0] exp_q[$];
   string       name_q[$];
   int          n_checks;
   int          n_pass;
   int          pcw_cnt, irw_cnt, pulse_at;

   task automatic add(input logic r, input logic [5:0] o, input logic j, input logic m,
                      input logic [3:0] s, input logic [18:0] c);
      vec_t v;
      v.rst = r; v.op = o; v.jr = j; v.rdy = m; v.st = s; v.ctl = c;
      tbl.push_back(v);
   endtask

   task automatic expect_val(input logic [22:0] e, input string nm);
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic check(input logic [22:0] act);
      logic [22:0] e;
      string       nm;
      n_checks++;
      if (exp_q.size() == 0) begin
         $display("FAIL scoreboard_empty: got %h with nothing expected", act);
         return;
      end
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (act === e) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
   end

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst_n = 1'b0; opcode = 6'h00; JumpReg = 1'b0; mem_ready = 1'b1;

      //   rst  op     jr  rdy  state  controls
      add(0, 6'h00, 0, 1, 4'd0,  C_ZERO);        // reset: FETCH strobes gated off
      add(0, 6'h00, 0, 1, 4'd0,  C_ZERO);
      add(1, 6'h00, 0, 1, 4'd0,  C_FETCH_RDY);   // R-type, JumpReg=0
      add(1, 6'h00, 0, 1, 4'd1,  C_DECODE);
      add(1, 6'h00, 0, 1, 4'd6,  C_EXEC);
      add(1, 6'h00, 0, 1, 4'd7,  C_RWB);
      add(1, 6'h23, 0, 1, 4'd0,  C_FETCH_RDY);   // lw with 3 wait cycles in MEMRD
      add(1, 6'h23, 0, 1, 4'd1,  C_DECODE);
      add(1, 6'h23, 0, 1, 4'd2,  C_MEMADR);
      add(1, 6'h23, 0, 0, 4'd3,  C_MEMRD);
      add(1, 6'h23, 0, 0, 4'd3,  C_MEMRD);
      add(1, 6'h23, 0, 0, 4'd3,  C_MEMRD);
      add(1, 6'h23, 0, 1, 4'd3,  C_MEMRD);
      add(1, 6'h23, 0, 0, 4'd4,  C_MEMWB);       // mem_ready ignored here
      add(1, 6'h2B, 0, 0, 4'd0,  C_FETCH_WAIT);  // sw, fetch stalled twice
      add(1, 6'h2B, 0, 0, 4'd0,  C_FETCH_WAIT);
      add(1, 6'h2B, 0, 1, 4'd0,  C_FETCH_RDY);
      add(1, 6'h2B, 0, 1, 4'd1,  C_DECODE);
      add(1, 6'h2B, 0, 1, 4'd2,  C_MEMADR);
      add(1, 6'h2B, 0, 0, 4'd5,  C_MEMWR);       // MemWrite held while waiting
      add(1, 6'h2B, 0, 1, 4'd5,  C_MEMWR);
      add(1, 6'h00, 0, 1, 4'd0,  C_FETCH_RDY);   // jr via JumpReg sampled in EXEC
      add(1, 6'h00, 0, 1, 4'd1,  C_DECODE);
      add(1, 6'h00, 1, 1, 4'd6,  C_EXEC);
      add(1, 6'h00, 0, 1, 4'd11, C_JR);
      add(1, 6'h04, 0, 1, 4'd0,  C_FETCH_RDY);   // beq
      add(1, 6'h04, 0, 1, 4'd1,  C_DECODE);
      add(1, 6'h04, 0, 1, 4'd8,  C_BRANCH);
      add(1, 6'h02, 0, 1, 4'd0,  C_FETCH_RDY);   // j
      add(1, 6'h02, 0, 1, 4'd1,  C_DECODE);
      add(1, 6'h02, 0, 1, 4'd9,  C_JUMP);
      add(1, 6'h0C, 0, 1, 4'd0,  C_FETCH_RDY);   // andi
      add(1, 6'h0C, 0, 1, 4'd1,  C_DECODE);
      add(1, 6'h0C, 0, 1, 4'd10, C_ANDI);
      add(1, 6'h0C, 0, 1, 4'd12, C_IWB);
      add(1, 6'h0D, 0, 1, 4'd0,  C_FETCH_RDY);   // ori
      add(1, 6'h0D, 0, 1, 4'd1,  C_DECODE);
      add(1, 6'h0D, 0, 1, 4'd10, C_ORI);
      add(1, 6'h0D, 0, 1, 4'd12, C_IWB);
      add(1, 6'h08, 0, 1, 4'd0,  C_FETCH_RDY);   // addi
      add(1, 6'h08, 0, 1, 4'd1,  C_DECODE);
      add(1, 6'h08, 0, 1, 4'd10, C_ADDI);
      add(1, 6'h08, 0, 1, 4'd12, C_IWB);
      add(1, 6'h3F, 0, 1, 4'd0,  C_FETCH_RDY);   // unsupported opcode
      add(1, 6'h3F, 0, 1, 4'd1,  C_DECODE_ILL);
      add(1, 6'h2B, 0, 1, 4'd0,  C_FETCH_RDY);   // sw interrupted by reset in MEMWR
      add(1, 6'h2B, 0, 1, 4'd1,  C_DECODE);
      add(1, 6'h2B, 0, 1, 4'd2,  C_MEMADR);
      add(1, 6'h2B, 0, 0, 4'd5,  C_MEMWR);
      add(0, 6'h2B, 0, 0, 4'd0,  C_ZERO);
      add(0, 6'h00, 0, 1, 4'd0,  C_ZERO);
      add(1, 6'h00, 0, 1, 4'd0,  C_FETCH_RDY);   // recovery; JumpReg high outside EXEC ignored
      add(1, 6'h00, 1, 1, 4'd1,  C_DECODE);
      add(1, 6'h00, 0, 1, 4'd6,  C_EXEC);
      add(1, 6'h00, 1, 1, 4'd7,  C_RWB);
      add(1, 6'h00, 0, 0, 4'd0,  C_FETCH_WAIT);

      for (int i = 0; i < tbl.size(); i++) begin
         @(posedge clk); #1;
         rst_n     = tbl[i].rst;
         opcode    = tbl[i].op;
         JumpReg   = tbl[i].jr;
         mem_ready = tbl[i].rdy;
         expect_val({tbl[i].st, tbl[i].ctl}, $sformatf("vec%0d_state%0d", i, tbl[i].st));
         @(negedge clk);
         check(obs_now);
      end

      // Stalled fetch: PCWrite/IRWrite must pulse exactly once, on the third FETCH cycle.
      @(posedge clk); #1;
      rst_n = 1'b0; opcode = 6'h00; JumpReg = 1'b0; mem_ready = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      pcw_cnt = 0; irw_cnt = 0; pulse_at = -1;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         mem_ready = (k == 2);
         @(negedge clk);
         if (PCWrite) begin pcw_cnt++; pulse_at = k; end
         if (IRWrite) irw_cnt++;
      end
      expect_val(23'd1, "stall_pcwrite_count");
      check(23'(pcw_cnt));
      expect_val(23'd1, "stall_irwrite_count");
      check(23'(irw_cnt));
      expect_val(23'd2, "stall_pulse_cycle");
      check(23'(pulse_at));
      @(posedge clk); #1;
      expect_val(23'd1, "stall_then_decode");
      @(negedge clk);
      check(23'(state));

      // Reset mid-cycle in RWB: RegWrite must drop without waiting for a clock.
      @(posedge clk); #1;          // EXEC
      @(posedge clk); #1;          // RWB
      expect_val(23'h1_7, "rwb_regwrite_before_reset");
      @(negedge clk);
      check({18'd0, RegWrite, state});
      #2 rst_n = 1'b0;
      expect_val(23'h0, "rwb_async_reset_drop");
      #1 check({18'd0, RegWrite, state});
      @(posedge clk); #1;
      rst_n = 1'b1; mem_ready = 1'b1;
      expect_val({4'd0, C_FETCH_RDY}, "fetch_after_async_reset");
      @(negedge clk);
      check(obs_now);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
